beat_timing_gen: RTL and testbench

- Generates the phase and beat timing consumed by the hardwired controller.
- Phase outputs: t1/t2/t3. Beat outputs: w1/w2/w3.
- Consumes the controller's short/long/stop requests and the panel start button qd.
- Sits between the panel/clock source and the controller; it closes the timing loop the controller drives.

---
 rtl/beat_timing_gen.sv | 130 +++++++++++++
 tb/tb_beat_timing_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/beat_timing_gen.sv
// -----------------------------------------------------------------------------
// beat_timing_gen
//
// Generates the phase (t1/t2/t3) and beat (w1/w2/w3) timing that drives the
// hardwired controller. The controller's short/long/stop requests are sampled
// only at end-of-beat (the last cycle of t3). The debounced panel button qd
// starts the machine on a rising edge.
//
// Parameters:
//   PHASE_CYCLES  clk cycles per phase (1..16)
//   CNT_W         width of the completed-instruction counter
//
// Ports:
//   clk        master clock, rising-edge
//   clr        synchronous active-high reset
//   qd         start button (level, debounced)
//   short      end instruction after beat w1
//   long       extend instruction to beat w3
//   stop       halt after the current beat
//   t1/t2/t3   phase strobes, one-hot while running, all low when stopped
//   w1/w2/w3   beat, always one-hot
//   running    machine is clocking
//   instr_cnt  completed instruction cycles (wraps)
// -----------------------------------------------------------------------------
module beat_timing_gen #(
  parameter int PHASE_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             qd,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic             t1,
  output logic             t2,
  output logic             t3,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             running,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int PC_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PHASE_CYCLES - 1);

  // One-hot encodings chosen so the state registers are the outputs directly.
  typedef enum logic [2:0] {
    PH_OFF = 3'b000,
    PH_T1  = 3'b001,
    PH_T2  = 3'b010,
    PH_T3  = 3'b100
  } phase_t;

  typedef enum logic [2:0] {
    BEAT_W1 = 3'b001,
    BEAT_W2 = 3'b010,
    BEAT_W3 = 3'b100
  } beat_t;

  phase_t          phase;
  beat_t           beat;
  beat_t           beat_next;
  logic [PC_W-1:0] pcnt;
  logic            qd_prev;
  logic            qd_rise;
  logic            phase_done;

  assign qd_rise    = qd & ~qd_prev;
  assign phase_done = (pcnt == PC_LAST);

  // Beat sequencing; only consumed at end-of-beat.
  always_comb begin
    // NOTE: default first so every path assigns beat_next and no latch is inferred.
    beat_next = beat;
    unique case (beat)
      BEAT_W1: beat_next = short ? BEAT_W1 : BEAT_W2;  // short beats long in w1
      BEAT_W2: beat_next = long  ? BEAT_W3 : BEAT_W1;
      BEAT_W3: beat_next = BEAT_W1;
      default: beat_next = BEAT_W1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      running   <= 1'b0;
      phase     <= PH_OFF;
      beat      <= BEAT_W1;
      pcnt      <= '0;
      qd_prev   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      qd_prev <= qd;
      if (running) begin
        // A qd edge while running is ignored, including the cycle stop lands.
        if (phase_done) begin
          pcnt <= '0;
          unique case (phase)
            PH_T1: phase <= PH_T2;
            PH_T2: phase <= PH_T3;
            default: begin
              // End-of-beat: commit the beat and count a completed instruction.
              beat <= beat_next;
              if (beat_next == BEAT_W1) instr_cnt <= instr_cnt + 1'b1;
              if (stop) begin
                running <= 1'b0;
                phase   <= PH_OFF;
              end else begin
                phase   <= PH_T1;
              end
            end
          endcase
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end else if (qd_rise) begin
        // Resume in the held beat, starting at t1.
        running <= 1'b1;
        phase   <= PH_T1;
        pcnt    <= '0;
      end
    end
  end

  assign {t3, t2, t1} = phase;
  assign {w3, w2, w1} = beat;

endmodule

// File: tb/tb_beat_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_beat_timing_gen
//
// Two instances share one stimulus stream: A (PHASE_CYCLES=1, CNT_W=8) and
// B (PHASE_CYCLES=3, CNT_W=2). A reference model computes each instance's
// timing from cycles elapsed since start; expected outputs are queued per
// cycle and a separate monitor pops and compares after each clock edge.
// -----------------------------------------------------------------------------
module tb_beat_timing_gen;

  localparam int P_A = 1;
  localparam int W_A = 8;
  localparam int P_B = 3;
  localparam int W_B = 2;

  logic clk = 1'b0;
  logic clr, qd, short, long, stop;

  logic t1_a, t2_a, t3_a, w1_a, w2_a, w3_a, run_a;
  logic [W_A-1:0] cnt_a;
  logic t1_b, t2_b, t3_b, w1_b, w2_b, w3_b, run_b;
  logic [W_B-1:0] cnt_b;

  always #5 clk = ~clk;

  beat_timing_gen #(.PHASE_CYCLES(P_A), .CNT_W(W_A)) dut_a (
    .clk(clk), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
    .t1(t1_a), .t2(t2_a), .t3(t3_a), .w1(w1_a), .w2(w2_a), .w3(w3_a),
    .running(run_a), .instr_cnt(cnt_a)
  );

  beat_timing_gen #(.PHASE_CYCLES(P_B), .CNT_W(W_B)) dut_b (
    .clk(clk), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
    .t1(t1_b), .t2(t2_b), .t3(t3_b), .w1(w1_b), .w2(w2_b), .w3(w3_b),
    .running(run_b), .instr_cnt(cnt_b)
  );

  typedef struct packed {
    logic [2:0] t;
    logic [2:0] w;
    logic       run;
    logic [7:0] cnt;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: k = cycles since the current run's first t1 cycle.
  int m_run  [2];
  int m_k    [2];
  int m_beat [2];
  int m_cnt  [2];
  int m_qdp;

  function automatic int p_of(input int i);
    return (i == 0) ? P_A : P_B;
  endfunction

  function automatic int mod_of(input int i);
    return (i == 0) ? (1 << W_A) : (1 << W_B);
  endfunction

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.run = (m_run[i] != 0);
    o.t   = m_run[i] ? 3'(1 << ((m_k[i] / p_of(i)) % 3)) : 3'b000;
    o.w   = 3'(1 << (m_beat[i] - 1));
    o.cnt = 8'(m_cnt[i]);
    return o;
  endfunction

  task automatic model_step(input bit c, input bit q, input bit s,
                            input bit l, input bit st);
    bit edge_seen;
    int nb;
    edge_seen = q && (m_qdp == 0);
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_run[i] = 0; m_k[i] = 0; m_beat[i] = 1; m_cnt[i] = 0;
      end else if (m_run[i] != 0) begin
        if (m_k[i] == 3 * p_of(i) - 1) begin
          case (m_beat[i])
            1:       nb = s ? 1 : 2;
            2:       nb = l ? 3 : 1;
            default: nb = 1;
          endcase
          m_beat[i] = nb;
          if (nb == 1) m_cnt[i] = (m_cnt[i] + 1) % mod_of(i);
          if (st) m_run[i] = 0;
          m_k[i] = 0;
        end else begin
          m_k[i] = m_k[i] + 1;
        end
      end else if (edge_seen) begin
        m_run[i] = 1;
        m_k[i]   = 0;
      end
    end
    m_qdp = c ? 0 : int'(q);
  endtask

  task automatic drive(input bit c, input bit q, input bit s,
                       input bit l, input bit st);
    exp_t e;
    @(negedge clk);
    clr = c; qd = q; short = s; long = l; stop = st;
    model_step(c, q, s, l, st);
    e.a = model_obs(0);
    e.b = model_obs(1);
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("a_t",   {29'd0, t3_a, t2_a, t1_a}, {29'd0, e.a.t});
        check("a_w",   {29'd0, w3_a, w2_a, w1_a}, {29'd0, e.a.w});
        check("a_run", {31'd0, run_a},            {31'd0, e.a.run});
        check("a_cnt", {24'd0, cnt_a},            {24'd0, e.a.cnt});
        check("b_t",   {29'd0, t3_b, t2_b, t1_b}, {29'd0, e.b.t});
        check("b_w",   {29'd0, w3_b, w2_b, w1_b}, {29'd0, e.b.w});
        check("b_run", {31'd0, run_b},            {31'd0, e.b.run});
        check("b_cnt", {30'd0, cnt_b},            {24'd0, e.b.cnt});
      end
    end
  end

  initial begin
    bit q_r;
    clr = 1'b1; qd = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_k[i] = 0; m_beat[i] = 1; m_cnt[i] = 0;
    end
    m_qdp = 0;

    // Reset and start.
    repeat (2) drive(1, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // short held: stays in w1, counts every beat.
    repeat (12) drive(0, 0, 1, 0, 0);
    // neither: w1/w2 alternate.
    repeat (18) drive(0, 0, 0, 0, 0);
    // long: w1/w2/w3.
    repeat (27) drive(0, 0, 0, 1, 0);
    // stop with qd held high: qd rise while running is ignored, then idle.
    repeat (9) drive(0, 1, 0, 0, 1);
    repeat (6) drive(0, 1, 0, 0, 0);
    // release, press: resume in held beat.
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    repeat (40) drive(0, 0, 0, 1, 0);
    // reset mid-beat.
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    // Randomized run.
    q_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(15) == 0) q_r = ~q_r;
      drive(($urandom_range(299) == 0),
            q_r,
            ($urandom_range(2) == 0),
            ($urandom_range(2) == 0),
            ($urandom_range(31) == 0));
    end

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
